// File: rtl/slc3_pkg.sv
// Shared types and constants for the SLC-3 memory-side logic.
package slc3_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {IDLE, WAIT, DONE, HOLD} mem_state_t;

    localparam word_t IO_ADDR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/slc3_sram_array.sv
// Single-port synchronous word RAM with a registered read port.
// The read register holds its value until the next read enable.
module slc3_sram_array
    import slc3_pkg::*;
#(
    parameter int unsigned Depth = 256
) (
    input  logic                     clk_i,
    input  logic [$clog2(Depth)-1:0] addr_i,
    input  logic                     we_i,
    input  word_t                    wdata_i,
    input  logic                     re_i,
    output word_t                    rdata_o
);

    word_t mem_q [Depth];
    word_t rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/slc3_mem_responder.sv
// Memory-side responder for the SLC-3 MAR/MDR bus: on-chip RAM, one I/O address,
// programmable wait states and a one-cycle ready pulse.
module slc3_mem_responder
    import slc3_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 2,
    parameter word_t       IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic        MEM_OE,
    input  logic        MEM_WE,
    input  logic [15:0] SW,
    output logic [15:0] MDR_in,
    output logic        R,
    output logic [15:0] HEX_OUT,
    output logic        ERR
);

    localparam int unsigned AW = $clog2(DEPTH);

    mem_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    word_t      addr_q, addr_d;
    word_t      wdata_q, wdata_d;
    logic       op_we_q, op_we_d;
    logic       err_q, err_d;
    word_t      hex_q;
    word_t      mdr_q;
    logic       src_ram_q;

    word_t acc_addr, acc_wdata, ram_rdata;
    logic  acc_we, enter_done, in_range, is_io, ram_we, ram_re;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_we_d = op_we_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (MEM_OE || MEM_WE) begin
                    addr_d  = MAR;
                    wdata_d = MDR;
                    op_we_d = MEM_WE;
                    if (MEM_OE && MEM_WE) begin
                        err_d = 1'b1;
                    end
                    if (WAIT_STATES == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = HOLD;
            HOLD: begin
                if (!MEM_OE && !MEM_WE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The access fires on the edge entering DONE so results are visible while R=1.
    // In IDLE (zero wait states) the latched values are not yet registered, so use the bus.
    always_comb begin
        acc_addr   = (state_q == IDLE) ? MAR : addr_q;
        acc_wdata  = (state_q == IDLE) ? MDR : wdata_q;
        acc_we     = (state_q == IDLE) ? MEM_WE : op_we_q;
        enter_done = (state_d == DONE) && !Reset;
        in_range   = 32'(acc_addr) < DEPTH;
        is_io      = (acc_addr == IO_ADDR);
        ram_we     = enter_done && acc_we && in_range;
        ram_re     = enter_done && !acc_we && in_range;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            op_we_q   <= 1'b0;
            err_q     <= 1'b0;
            hex_q     <= '0;
            mdr_q     <= '0;
            src_ram_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_we_q <= op_we_d;
            err_q   <= err_d;
            if (enter_done) begin
                if (acc_we) begin
                    if (!in_range && is_io) begin
                        hex_q <= acc_wdata;
                    end
                end else begin
                    src_ram_q <= in_range;
                    if (!in_range) begin
                        mdr_q <= is_io ? SW : '0;
                    end
                end
            end
        end
    end

    slc3_sram_array #(
        .Depth (DEPTH)
    ) u_sram (
        .clk_i   (Clk),
        .addr_i  (acc_addr[AW-1:0]),
        .we_i    (ram_we),
        .wdata_i (acc_wdata),
        .re_i    (ram_re),
        .rdata_o (ram_rdata)
    );

    assign MDR_in  = src_ram_q ? ram_rdata : mdr_q;
    assign R       = (state_q == DONE);
    assign HEX_OUT = hex_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Self-checking bench for slc3_mem_responder: vector table plus a scoreboard of
// expected {MDR_in, HEX_OUT} values popped on every R pulse.
module tb_slc3_mem_responder;

    localparam int WS = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] MAR = '0;
    logic [15:0] MDR = '0;
    logic        MEM_OE = 1'b0;
    logic        MEM_WE = 1'b0;
    logic [15:0] SW = 16'h1234;
    logic [15:0] MDR_in;
    logic        R;
    logic [15:0] HEX_OUT;
    logic        ERR;

    slc3_mem_responder #(
        .DEPTH       (256),
        .WAIT_STATES (WS),
        .IO_ADDR     (16'hFFFF)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .MAR     (MAR),
        .MDR     (MDR),
        .MEM_OE  (MEM_OE),
        .MEM_WE  (MEM_WE),
        .SW      (SW),
        .MDR_in  (MDR_in),
        .R       (R),
        .HEX_OUT (HEX_OUT),
        .ERR     (ERR)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] mdr;
        logic [15:0] hex;
    } exp_t;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp_rd;
        logic [15:0] exp_hex;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard: every R pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (R) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_r actual=1 required=0 at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mdr_in_on_r", 32'(MDR_in), 32'(e.mdr));
                check("hex_out_on_r", 32'(HEX_OUT), 32'(e.hex));
            end
        end
    end

    task automatic txn(input bit wr, input bit both, input logic [15:0] addr,
                       input logic [15:0] data, input logic [15:0] exp_mdr,
                       input logic [15:0] exp_hex);
        exp_t e;
        int   n;
        bit   seen;
        @(negedge Clk);
        MAR    = addr;
        MDR    = data;
        MEM_WE = wr | both;
        MEM_OE = !wr | both;
        e.mdr  = exp_mdr;
        e.hex  = exp_hex;
        sb.push_back(e);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 50) begin
            @(negedge Clk);
            n++;
            seen = R;
        end
        if (!seen) begin
            void'(sb.pop_back());
        end
        check("r_latency", 32'(n), 32'(WS + 1));
        MEM_OE = 1'b0;
        MEM_WE = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    vec_t        vecs[15];
    logic [15:0] exp_mdr;
    int          pulses;

    initial begin
        vecs[0]  = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 16'h0000};
        vecs[2]  = '{1'b1, 16'h0005, 16'h1357, 16'h0000, 16'h0000};
        vecs[3]  = '{1'b0, 16'h0005, 16'h0000, 16'h1357, 16'h0000};
        vecs[4]  = '{1'b1, 16'h00FF, 16'h0F0F, 16'h0000, 16'h0000};
        vecs[5]  = '{1'b0, 16'hFFFF, 16'h0000, 16'h1234, 16'h0000};
        vecs[6]  = '{1'b1, 16'hFFFF, 16'h00A5, 16'h0000, 16'h00A5};
        vecs[7]  = '{1'b0, 16'h00FF, 16'h0000, 16'h0F0F, 16'h00A5};
        vecs[8]  = '{1'b1, 16'h0000, 16'hCAFE, 16'h0000, 16'h00A5};
        vecs[9]  = '{1'b0, 16'h0800, 16'h0000, 16'h0000, 16'h00A5};
        vecs[10] = '{1'b1, 16'h0800, 16'hDEAD, 16'h0000, 16'h00A5};
        vecs[11] = '{1'b0, 16'h0000, 16'h0000, 16'hCAFE, 16'h00A5};
        vecs[12] = '{1'b1, 16'h0020, 16'h1111, 16'h0000, 16'h00A5};
        vecs[13] = '{1'b0, 16'h0020, 16'h0000, 16'h1111, 16'h00A5};
        vecs[14] = '{1'b0, 16'h00FF, 16'h0000, 16'h0F0F, 16'h00A5};

        // Reset, then idle outputs for 10 cycles.
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            check("idle_r", 32'(R), 32'd0);
            check("idle_mdr_in", 32'(MDR_in), 32'd0);
            check("idle_hex_out", 32'(HEX_OUT), 32'd0);
            check("idle_err", 32'(ERR), 32'd0);
        end

        // Table: writes leave MDR_in at the last read value.
        exp_mdr = 16'h0000;
        for (int i = 0; i < 15; i++) begin
            if (!vecs[i].wr) begin
                exp_mdr = vecs[i].exp_rd;
            end
            txn(vecs[i].wr, 1'b0, vecs[i].addr, vecs[i].data, exp_mdr, vecs[i].exp_hex);
        end
        check("err_after_table", 32'(ERR), 32'd0);

        // Held read yields exactly one R until the request drops.
        @(negedge Clk);
        MAR    = 16'h0005;
        MEM_OE = 1'b1;
        sb.push_back('{16'h1357, 16'h00A5});
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            pulses += int'(R);
        end
        check("held_oe_pulses", 32'(pulses), 32'd1);
        MEM_OE = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            pulses += int'(R);
        end
        check("dropped_oe_pulses", 32'(pulses), 32'd0);
        txn(1'b0, 1'b0, 16'h0005, 16'h0000, 16'h1357, 16'h00A5);

        // Reset during WAIT aborts the write.
        @(negedge Clk);
        MAR    = 16'h0020;
        MDR    = 16'h5555;
        MEM_WE = 1'b1;
        @(negedge Clk);
        Reset  = 1'b1;
        MEM_WE = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        check("reset_hex_out", 32'(HEX_OUT), 32'd0);
        check("reset_mdr_in", 32'(MDR_in), 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            pulses += int'(R);
        end
        check("aborted_pulses", 32'(pulses), 32'd0);
        txn(1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1111, 16'h0000);

        // OE and WE together: performed as a write, ERR sticky until reset.
        txn(1'b1, 1'b1, 16'h0030, 16'h7777, 16'h1111, 16'h0000);
        check("err_set", 32'(ERR), 32'd1);
        txn(1'b0, 1'b0, 16'h0030, 16'h0000, 16'h7777, 16'h0000);
        check("err_sticky", 32'(ERR), 32'd1);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("err_cleared", 32'(ERR), 32'd0);
        check("mdr_in_cleared", 32'(MDR_in), 32'd0);

        repeat (3) @(negedge Clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
